// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the UART message decoder.
package uart_msg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CTRL    = 2'd0,
        SLOT    = 2'd1,
        COMMIT  = 2'd2,
        ILLEGAL = 2'd3
    } addr_kind_t;

    localparam int unsigned ADDR_CTRL = 0;

    // Bit positions inside the value field of a control byte
    localparam int unsigned CTRL_FIN_BIT   = 0;
    localparam int unsigned CTRL_DEAL_BIT  = 1;
    localparam int unsigned CTRL_START_BIT = 2;
    localparam int unsigned CTRL_CLR_BIT   = 3;
    localparam int unsigned CTRL_W         = 4;

    typedef struct packed {
        logic start;
        logic deal;
        logic dealer_finished;
    } ctrl_flags_t;

endpackage

// File: rtl/uart_msg_decoder_if.sv
// RX FIFO read port: head byte, empty flag and pop strobe.
interface uart_msg_decoder_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] read_data;
    logic              rx_empty;
    logic              rd_uart;

    modport master (output read_data, output rx_empty, input rd_uart);
    modport slave  (input read_data, input rx_empty, output rd_uart);
endinterface

// File: rtl/uart_msg_slot_bank.sv
// Card slot registers and per-slot update pulses.
// With UART_DEC_CHECKSUM_EN defined, slot writes land in a shadow bank and
// are only applied by a COMMIT byte whose value matches the running XOR.
module uart_msg_slot_bank #(
    parameter int unsigned VAL_W   = 4,
    parameter int unsigned N_SLOTS = 9,
    parameter int unsigned IDX_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     slot_wr,
    input  logic [IDX_W-1:0]         slot_idx,
    input  logic [VAL_W-1:0]         wr_val,
    input  logic                     clr_all,
`ifdef UART_DEC_CHECKSUM_EN
    input  logic                     commit,
    output logic                     commit_bad_c,
`endif
    output logic [N_SLOTS*VAL_W-1:0] card_values,
    output logic [N_SLOTS-1:0]       slot_upd
);

    localparam int unsigned BANK_W = N_SLOTS * VAL_W;

`ifdef UART_DEC_CHECKSUM_EN
    logic [BANK_W-1:0]  shadow;
    logic [N_SLOTS-1:0] dirty;
    logic [VAL_W-1:0]   chk;

    assign commit_bad_c = commit && (wr_val != chk);

    // Shadow/dirty/checksum tracking and atomic commit into the live bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            card_values <= '0;
            slot_upd    <= '0;
            shadow      <= '0;
            dirty       <= '0;
            chk         <= '0;
        end else begin
            slot_upd <= '0;
            if (clr_all) begin
                card_values <= '0;
                shadow      <= '0;
                dirty       <= '0;
                chk         <= '0;
                slot_upd    <= '1;
            end else if (slot_wr) begin
                for (int unsigned i = 0; i < N_SLOTS; i++) begin
                    if (slot_idx == IDX_W'(i)) begin
                        shadow[i*VAL_W +: VAL_W] <= wr_val;
                        dirty[i]                 <= 1'b1;
                    end
                end
                chk <= chk ^ wr_val;
            end else if (commit) begin
                if (commit_bad_c) begin
                    shadow <= card_values;
                end else begin
                    card_values <= shadow;
                    slot_upd    <= dirty;
                end
                dirty <= '0;
                chk   <= '0;
            end
        end
    end
`else
    // Direct slot writes; every write pulses its slot, changed or not
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            card_values <= '0;
            slot_upd    <= '0;
        end else begin
            slot_upd <= '0;
            if (clr_all) begin
                card_values <= '0;
                slot_upd    <= '1;
            end else if (slot_wr) begin
                for (int unsigned i = 0; i < N_SLOTS; i++) begin
                    if (slot_idx == IDX_W'(i)) begin
                        card_values[i*VAL_W +: VAL_W] <= wr_val;
                        slot_upd[i]                   <= 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: rtl/uart_msg_decoder.sv
// UART message decoder: pops one byte per three cycles from the RX FIFO,
// decodes {value,address} into control flags and card slots, counts errors.
// Optional feature macro: UART_DEC_CHECKSUM_EN (shadowed slot writes + COMMIT).
module uart_msg_decoder
    import uart_msg_pkg::*;
#(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned VAL_W   = 4,
    parameter int unsigned N_SLOTS = 9,
    parameter int unsigned ERR_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_msg_decoder_if.slave        rx,
    output logic                     decoded_dealer_finished,
    output logic                     decoded_deal,
    output logic                     decoded_start,
    output logic                     ctrl_stb,
    output logic [N_SLOTS*VAL_W-1:0] card_values,
    output logic [N_SLOTS-1:0]       slot_upd,
    output logic                     addr_err,
    output logic [ERR_W-1:0]         err_cnt
);

    localparam int unsigned BYTE_W = ADDR_W + VAL_W;
    localparam int unsigned VX_W   = (VAL_W < CTRL_W) ? CTRL_W : VAL_W;

    state_t            state;
    state_t            next_state;
    logic [BYTE_W-1:0] byte_q;
    logic              rd_uart_q;
    ctrl_flags_t       flags_q;

    logic [ADDR_W-1:0] addr_c;
    logic [VAL_W-1:0]  val_c;
    logic [VX_W-1:0]   val_x_c;
    logic [ADDR_W-1:0] slot_idx_c;
    addr_kind_t        kind_c;
    logic              pop_c;
    logic              slot_wr_c;
    logic              clr_all_c;
    logic              commit_bad_c;
    logic              err_c;
    logic              ctrl_c;
`ifdef UART_DEC_CHECKSUM_EN
    logic              commit_c;
`endif

    assign rx.rd_uart              = rd_uart_q;
    assign decoded_dealer_finished = flags_q.dealer_finished;
    assign decoded_deal            = flags_q.deal;
    assign decoded_start           = flags_q.start;

    // Next-state logic: a byte is taken only from IDLE when the FIFO is non-empty
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx.rx_empty) next_state = POP;
            POP:     next_state = SETTLE;
            SETTLE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register, byte latch and registered one-cycle pop strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            byte_q    <= '0;
            rd_uart_q <= 1'b0;
        end else begin
            state     <= next_state;
            rd_uart_q <= (next_state == POP);
            if (state == IDLE && !rx.rx_empty) begin
                byte_q <= BYTE_W'(rx.read_data);
            end
        end
    end

    assign addr_c  = byte_q[ADDR_W-1:0];
    assign val_c   = byte_q[BYTE_W-1 -: VAL_W];
    assign val_x_c = VX_W'(val_c);
    assign pop_c   = (state == POP);

    // Address classification of the latched byte
    always_comb begin
        kind_c     = ILLEGAL;
        slot_idx_c = ADDR_W'(addr_c - ADDR_W'(1));
        if (addr_c == ADDR_W'(ADDR_CTRL)) begin
            kind_c = CTRL;
        end else if (addr_c <= ADDR_W'(N_SLOTS)) begin
            kind_c = SLOT;
`ifdef UART_DEC_CHECKSUM_EN
        end else if (addr_c == {ADDR_W{1'b1}}) begin
            kind_c = COMMIT;
`endif
        end
    end

    assign ctrl_c    = pop_c && (kind_c == CTRL);
    assign slot_wr_c = pop_c && (kind_c == SLOT);
    assign clr_all_c = ctrl_c && val_x_c[CTRL_CLR_BIT];
`ifdef UART_DEC_CHECKSUM_EN
    assign commit_c  = pop_c && (kind_c == COMMIT);
`else
    assign commit_bad_c = 1'b0;
`endif
    assign err_c     = pop_c && ((kind_c == ILLEGAL) || commit_bad_c);

    // Control levels, control/error pulses and saturating error counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q  <= '0;
            ctrl_stb <= 1'b0;
            addr_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            ctrl_stb <= ctrl_c;
            addr_err <= err_c;
            if (ctrl_c) begin
                flags_q.dealer_finished <= val_x_c[CTRL_FIN_BIT];
                flags_q.deal            <= val_x_c[CTRL_DEAL_BIT];
                flags_q.start           <= val_x_c[CTRL_START_BIT];
            end
            if (err_c && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

    uart_msg_slot_bank #(
        .VAL_W   (VAL_W),
        .N_SLOTS (N_SLOTS),
        .IDX_W   (ADDR_W)
    ) u_slot_bank (
        .clk          (clk),
        .rst          (rst),
        .slot_wr      (slot_wr_c),
        .slot_idx     (slot_idx_c),
        .wr_val       (val_c),
        .clr_all      (clr_all_c),
`ifdef UART_DEC_CHECKSUM_EN
        .commit       (commit_c),
        .commit_bad_c (commit_bad_c),
`endif
        .card_values  (card_values),
        .slot_upd     (slot_upd)
    );

endmodule

// File: tb/tb_uart_msg_decoder.sv
// Scoreboard bench for uart_msg_decoder: a behavioural model queues the
// expected output event per byte; a negedge monitor pops and compares.
module tb_uart_msg_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        decoded_dealer_finished, decoded_deal, decoded_start;
    logic        ctrl_stb, addr_err;
    logic [35:0] card_values;
    logic [8:0]  slot_upd;
    logic [7:0]  err_cnt;

    uart_msg_decoder_if #(.DATA_W(8)) rx ();

    uart_msg_decoder dut (
        .clk                     (clk),
        .rst                     (rst),
        .rx                      (rx),
        .decoded_dealer_finished (decoded_dealer_finished),
        .decoded_deal            (decoded_deal),
        .decoded_start           (decoded_start),
        .ctrl_stb                (ctrl_stb),
        .card_values             (card_values),
        .slot_upd                (slot_upd),
        .addr_err                (addr_err),
        .err_cnt                 (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  upd;
        logic        ctrl;
        logic        aerr;
        logic [35:0] cards;
        logic [2:0]  flags;
        logic [7:0]  err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_pulse = -100;
    int         pulses[$];

    // Reference model state
    logic [3:0] m_slot[9];
    logic [3:0] m_shadow[9];
    logic [8:0] m_dirty;
    logic [3:0] m_chk;
    logic [2:0] m_flags;
    int         m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_slot[i]   = 4'h0;
            m_shadow[i] = 4'h0;
        end
        m_dirty = '0;
        m_chk   = '0;
        m_flags = '0;
        m_err   = 0;
    endtask

    function automatic logic [35:0] model_cards();
        logic [35:0] r;
        for (int i = 0; i < 9; i++) r[i*4 +: 4] = m_slot[i];
        return r;
    endfunction

    task automatic model_err();
        if (m_err != 255) m_err++;
    endtask

    // Queue a byte into the FIFO and the expected response into the scoreboard
    task automatic send(input logic [7:0] b);
        logic [3:0] a;
        logic [3:0] v;
        exp_t       e;
        a = b[3:0];
        v = b[7:4];
        e.upd  = '0;
        e.ctrl = 1'b0;
        e.aerr = 1'b0;
        fifo.push_back(b);
        if (a == 4'd0) begin
            m_flags = v[2:0];
            e.ctrl  = 1'b1;
            if (v[3]) begin
                for (int i = 0; i < 9; i++) begin
                    m_slot[i]   = 4'h0;
                    m_shadow[i] = 4'h0;
                end
                m_dirty = '0;
                m_chk   = '0;
                e.upd   = 9'h1FF;
            end
        end else if (a <= 4'd9) begin
`ifdef UART_DEC_CHECKSUM_EN
            m_shadow[a-1] = v;
            m_dirty[a-1]  = 1'b1;
            m_chk         = m_chk ^ v;
`else
            m_slot[a-1] = v;
            e.upd[a-1]  = 1'b1;
`endif
`ifdef UART_DEC_CHECKSUM_EN
        end else if (a == 4'hF) begin
            if (v == m_chk) begin
                for (int i = 0; i < 9; i++) if (m_dirty[i]) m_slot[i] = m_shadow[i];
                e.upd = m_dirty;
            end else begin
                for (int i = 0; i < 9; i++) m_shadow[i] = m_slot[i];
                e.aerr = 1'b1;
                model_err();
            end
            m_dirty = '0;
            m_chk   = '0;
`endif
        end else begin
            e.aerr = 1'b1;
            model_err();
        end
        e.cards = model_cards();
        e.flags = m_flags;
        e.err   = 8'(m_err);
        if (e.upd != '0 || e.ctrl || e.aerr) exp_q.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: pops on rd_uart at the edge, flags update just after
    initial begin
        rx.rx_empty  = 1'b1;
        rx.read_data = 8'h00;
        forever begin
            @(posedge clk);
            if (rx.rd_uart) begin
                checks++;
                if (fifo.size() == 0) begin
                    errors++;
                    $display("FAIL pop_when_empty: rd_uart=1 expected 0 (t=%0t)", $time);
                end else begin
                    void'(fifo.pop_front());
                end
            end
            #1;
            rx.rx_empty  = (fifo.size() == 0);
            rx.read_data = (fifo.size() != 0) ? fifo[0] : 8'h00;
        end
    end

    // Monitor: pop-strobe spacing and scoreboard compare on every output event
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (rx.rd_uart) begin
                check("rd_uart_gap_ok", 64'(cyc - last_pulse >= 3), 64'd1);
                last_pulse = cyc;
                pulses.push_back(cyc);
            end
            if (slot_upd != '0 || ctrl_stb || addr_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: upd=%0h ctrl=%0b aerr=%0b expected none",
                             slot_upd, ctrl_stb, addr_err);
                end else begin
                    e = exp_q.pop_front();
                    check("pulses", 64'({slot_upd, ctrl_stb, addr_err}), 64'({e.upd, e.ctrl, e.aerr}));
                    check("card_values", 64'(card_values), 64'(e.cards));
                    check("flags", 64'({decoded_start, decoded_deal, decoded_dealer_finished}), 64'(e.flags));
                    check("err_cnt", 64'(err_cnt), 64'(e.err));
                end
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: fifo=%0d pending=%0d expected 0", fifo.size(), exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_uart"}, 64'(rx.rd_uart), 64'd0);
        check({tag, "_cards"}, 64'(card_values), 64'd0);
        check({tag, "_pulses"}, 64'({slot_upd, ctrl_stb, addr_err}), 64'd0);
        check({tag, "_flags"}, 64'({decoded_start, decoded_deal, decoded_dealer_finished}), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #20;
        check_all_zero("reset");
        #2 rst = 1'b1;
        @(negedge clk);

        // Single slot byte: latency and pulse timing
        send(8'h51);
        @(posedge clk); #2;
        check("t1_rd_uart_c0", 64'(rx.rd_uart), 64'd0);
        @(posedge clk); #2;
        check("t1_rd_uart_c1", 64'(rx.rd_uart), 64'd1);
        @(posedge clk); #2;
        check("t1_rd_uart_c2", 64'(rx.rd_uart), 64'd0);
`ifndef UART_DEC_CHECKSUM_EN
        check("t1_slot_upd", 64'(slot_upd), 64'h001);
        check("t1_slot0", 64'(card_values[3:0]), 64'h5);
`endif
        drain(100);

        // Control byte, then clear-all
        send(8'h92);
        send(8'hF9);
        send(8'h60);
        drain(100);
        check("t2_flags", 64'({decoded_start, decoded_deal, decoded_dealer_finished}), 64'b110);
`ifndef UART_DEC_CHECKSUM_EN
        check("t2_cards", 64'(card_values), 64'hF_0000_0095);
`endif
        send(8'h80);
        drain(100);
        check("t2_clear_cards", 64'(card_values), 64'd0);
        check("t2_clear_flags", 64'({decoded_start, decoded_deal, decoded_dealer_finished}), 64'd0);

        // Illegal addresses and counter saturation
        send(8'h3A);
        send(8'h3E);
        drain(100);
        check("t3_err_cnt_2", 64'(err_cnt), 64'd2);
        send(8'h7F);
        drain(100);
        check("t3_err_cnt_3", 64'(err_cnt), 64'd3);
        for (int i = 0; i < 297; i++) send({4'(i), 4'hC});
        drain(4000);
        check("t3_err_sat", 64'(err_cnt), 64'd255);
        check("t3_cards_kept", 64'(card_values), 64'd0);

        // Four queued bytes: exactly four pops, three cycles apart
        pulses.delete();
        send(8'h13);
        send(8'h24);
        send(8'h35);
        send(8'h46);
        drain(100);
        check("t4_pop_count", 64'(pulses.size()), 64'd4);
        if (pulses.size() == 4) begin
            for (int i = 1; i < 4; i++) check("t4_pop_spacing", 64'(pulses[i] - pulses[i-1]), 64'd3);
        end
        send(8'h13);
        drain(100);

`ifdef UART_DEC_CHECKSUM_EN
        // Shadowed writes applied together by a matching COMMIT
        send(8'h80);
        send(8'h72);
        send(8'h33);
        send(8'h4F);
        drain(100);
        check("t5_commit_cards", 64'(card_values), 64'h0_0000_0370);
        send(8'h5F);
        drain(100);
        check("t5_bad_commit_cards", 64'(card_values), 64'h0_0000_0370);
`endif

        // Asynchronous reset in the middle of POP
        send(8'h57);
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("t6_in_pop", 64'(rx.rd_uart), 64'd1);
        #1 rst = 1'b0;
        #1;
        check_all_zero("t6_async");
        fifo.delete();
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check_all_zero("t6_release");
        send(8'h21);
        drain(100);
`ifndef UART_DEC_CHECKSUM_EN
        check("t6_resume_cards", 64'(card_values), 64'h2);
`endif

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
